// File: rtl/fc_argmax_scheduler.sv
// Final classification stage: buffers one frame of signed FC scores, then runs a
// one-element-per-cycle signed argmax scan and returns the winner over valid/ready.
module fc_argmax_scheduler #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IDX_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class,
  output logic [DATA_W-1:0] out_score,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  scan_q, scan_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W-1:0]  out_class_q, out_class_d;
  logic [DATA_W-1:0] out_score_q, out_score_d;
  logic [DATA_W-1:0] score_buf_q [NUM_CLASSES];
  logic              buf_we;
  logic              cand_gt;

  // Strict compare so that equal scores keep the earlier (lower) index.
  assign cand_gt = $signed(score_buf_q[scan_q]) > $signed(max_q);

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_class = out_class_q;
  assign out_score = out_score_q;

  // Next-state and datapath update for the idle/load/scan/done sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    scan_d      = scan_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    buf_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (count_q == LastIdx) begin
            state_d   = StScan;
            // Slot 0 may be the beat being written right now.
            max_d     = (count_q == '0) ? in_data : score_buf_q[0];
            max_idx_d = '0;
            scan_d    = IDX_W'(1);
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StScan: begin
        if (cand_gt) begin
          max_d     = score_buf_q[scan_q];
          max_idx_d = scan_q;
        end
        if (scan_q == LastIdx) begin
          state_d     = StDone;
          out_class_d = cand_gt ? scan_q : max_idx_q;
          out_score_d = cand_gt ? score_buf_q[scan_q] : max_q;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      scan_q      <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      out_class_q <= '0;
      out_score_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      scan_q      <= scan_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
    end
  end

  // Score buffer; contents are irrelevant after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (buf_we) score_buf_q[count_q] <= in_data;
  end

endmodule

// File: tb/tb_fc_argmax_scheduler.sv
// Directed self-checking bench for fc_argmax_scheduler (default parameters).
module tb_fc_argmax_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_class;
  logic [15:0] out_score;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  typedef logic [15:0] frame_t [10];

  fc_argmax_scheduler #(
    .NUM_CLASSES(10),
    .DATA_W     (16),
    .IDX_W      (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_score(out_score),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Count completed result handshakes.
  always @(posedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) hs_count <= hs_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame, push its 10 scores, then wait for out_valid counting edges.
  task automatic load_frame(input frame_t s, input bit gaps, output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = s[k];
      tick();
    end
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_handshake out_valid=%b in_ready=%b want=0/0",
                         out_valid, in_ready);
    end
    checks++;
    if (out_class !== 4'd0 || out_score !== 16'd0) begin
      errors++; $display("FAIL reset_result got=%0d/%h want=0/0000", out_class, out_score);
    end
  endtask

  task automatic test_ascending();
    frame_t s = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    int lat;
    int hs0;
    out_ready = 1'b1;
    hs0 = hs_count;
    load_frame(s, 1'b0, lat);
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL asc_latency got=%0d want=9", lat);
    end
    checks++;
    if (out_class !== 4'd9 || out_score !== 16'd9) begin
      errors++; $display("FAIL asc_result got=%0d/%h want=9/0009", out_class, out_score);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL asc_busy_done got=%b want=1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL asc_after_hs busy=%b out_valid=%b want=0/0", busy, out_valid);
    end
    checks++;
    if (hs_count - hs0 !== 1 || out_class !== 4'd9 || out_score !== 16'd9) begin
      errors++; $display("FAIL asc_hold hs=%0d class=%0d score=%h want=1/9/0009",
                         hs_count - hs0, out_class, out_score);
    end
  endtask

  task automatic test_ties();
    frame_t s = '{default: 16'h0005};
    int lat;
    out_ready = 1'b1;
    load_frame(s, 1'b0, lat);
    checks++;
    if (lat !== 9 || out_class !== 4'd0 || out_score !== 16'h0005) begin
      errors++; $display("FAIL ties got lat=%0d class=%0d score=%h want=9/0/0005",
                         lat, out_class, out_score);
    end
    tick();
  endtask

  task automatic test_negative();
    frame_t s = '{16'hFFF0, 16'h8000, 16'hFFFF, 16'hFFFE, 16'h8001,
                  16'hFFF5, 16'hFFFF, 16'h8000, 16'hFFF0, 16'hFFFA};
    int lat;
    out_ready = 1'b1;
    load_frame(s, 1'b0, lat);
    checks++;
    if (lat !== 9 || out_class !== 4'd2 || out_score !== 16'hFFFF) begin
      errors++; $display("FAIL negative got lat=%0d class=%0d score=%h want=9/2/FFFF",
                         lat, out_class, out_score);
    end
    tick();
  endtask

  task automatic test_backpressure();
    frame_t s = '{16'd10, 16'h8000, 16'd300, 16'hFFFF, 16'h7FFF,
                  16'h7FFE, 16'd0, 16'h7FFF, 16'd5, 16'h8001};
    int lat;
    int hs0;
    bit stable = 1'b1;
    out_ready = 1'b0;
    hs0 = hs_count;
    load_frame(s, 1'b1, lat);
    checks++;
    if (lat !== 9 || out_class !== 4'd4 || out_score !== 16'h7FFF) begin
      errors++; $display("FAIL bp_result got lat=%0d class=%0d score=%h want=9/4/7FFF",
                         lat, out_class, out_score);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid !== 1'b1 || out_class !== 4'd4 || out_score !== 16'h7FFF) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++; $display("FAIL bp_stable got unstable class=%0d score=%h want=4/7FFF held",
                         out_class, out_score);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || hs_count - hs0 !== 1) begin
      errors++; $display("FAIL bp_handshake out_valid=%b hs=%0d want=0/1",
                         out_valid, hs_count - hs0);
    end
  endtask

  task automatic test_abort();
    frame_t s = '{16'd1, 16'd2, 16'd3, 16'hFF00, 16'd50, 16'd99, 16'd0, 16'd100, 16'd100, 16'd7};
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h7FFF;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_class !== 4'd0 || out_score !== 16'd0) begin
      errors++; $display("FAIL abort_reset busy=%b class=%0d score=%h want=0/0/0000",
                         busy, out_class, out_score);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_result got=%0d valid cycles want=0", seen);
    end
    load_frame(s, 1'b0, lat);
    checks++;
    if (lat !== 9 || out_class !== 4'd7 || out_score !== 16'd100) begin
      errors++; $display("FAIL abort_next got lat=%0d class=%0d score=%0d want=9/7/100",
                         lat, out_class, out_score);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    frame_t s = '{16'd3, 16'hFFFE, 16'd8, 16'd1, 16'd0, 16'd8, 16'd42, 16'd2, 16'd41, 16'hFFFF};
    int lat = 0;
    int hs0;
    int seen = 0;
    out_ready = 1'b0;
    hs0 = hs_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = s[k];
      start    = (k == 5);
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 9 || out_class !== 4'd6 || out_score !== 16'd42) begin
      errors++; $display("FAIL start_ignored_result got lat=%0d class=%0d score=%0d want=9/6/42",
                         lat, out_class, out_score);
    end
    start = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL start_in_done got out_valid=%b want=1", out_valid);
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hs_count - hs0 !== 1) begin
      errors++; $display("FAIL start_with_hs busy=%b hs=%0d want=0/1", busy, hs_count - hs0);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || hs_count - hs0 !== 1) begin
      errors++; $display("FAIL start_single_result got busy cycles=%0d hs=%0d want=0/1",
                         seen, hs_count - hs0);
    end
  endtask

  task automatic test_idle_in_valid();
    frame_t s = '{16'd7, 16'd9, 16'hFFFF, 16'd50, 16'd49, 16'd50, 16'd0, 16'd12, 16'd3, 16'd1};
    int lat;
    bit idle_ok = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (in_ready !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (idle_ok !== 1'b1) begin
      errors++; $display("FAIL idle_in_valid in_ready=%b busy=%b want=0/0", in_ready, busy);
    end
    load_frame(s, 1'b0, lat);
    checks++;
    if (lat !== 9 || out_class !== 4'd3 || out_score !== 16'd50) begin
      errors++; $display("FAIL idle_next_frame got lat=%0d class=%0d score=%0d want=9/3/50",
                         lat, out_class, out_score);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_ties();
    test_negative();
    test_backpressure();
    test_abort();
    test_ignored_start();
    test_idle_in_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
